// File: rtl/pwm_config_sync.sv
// Shadow/active configuration registers for the GPIO PWM core. Shadow values are
// loaded into the active outputs only at a frame boundary of a mirrored PWM counter.
`timescale 1ns/1ps
module pwm_config_sync #(
  parameter int CORE_WIDTH        = 4,
  parameter int PWM_COUNTER_WIDTH = 16,
  parameter int ADDR_WIDTH        = 4
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic                                    wr_en,
  input  logic [ADDR_WIDTH-1:0]                   wr_addr,
  input  logic [PWM_COUNTER_WIDTH-1:0]            wr_data,
  input  logic [ADDR_WIDTH-1:0]                   rd_addr,
  output logic [PWM_COUNTER_WIDTH-1:0]            rd_data,
  output logic [PWM_COUNTER_WIDTH-1:0]            period,
  output logic [PWM_COUNTER_WIDTH*CORE_WIDTH:0]   duty,
  output logic                                    pending,
  output logic                                    frame_start,
  output logic                                    commit_done
);

  localparam int W = PWM_COUNTER_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] PERIOD_ADDR = '0;
  localparam logic [ADDR_WIDTH-1:0] CTRL_ADDR   = ADDR_WIDTH'(CORE_WIDTH + 1);

  logic [W-1:0] period_sh;
  logic [W-1:0] duty_sh  [CORE_WIDTH];
  logic [W-1:0] duty_act [CORE_WIDTH];
  logic [W-1:0] cnt;

  logic         wrap;
  logic         ctrl_wr;
  logic         arm;
  logic         abort;
  logic         commit;
  logic         pending_next;
  logic [W-1:0] rd_next;

  // Same wrap rule as the PWM core's counter; the period used here is the one
  // still active during this cycle, even on a commit edge.
  assign wrap        = (cnt > period) || (cnt == '1);
  assign frame_start = (cnt == '0);

  assign ctrl_wr = wr_en && (wr_addr == CTRL_ADDR);
  assign abort   = ctrl_wr && wr_data[1];
  assign arm     = ctrl_wr && wr_data[0];

  // An arm landing on the wrap cycle commits immediately; abort always wins.
  assign commit       = wrap && (pending || arm) && !abort;
  assign pending_next = !abort && !commit && (pending || arm);

  // NOTE: every signal assigned in an always_comb gets a default first, otherwise
  // an address that matches no branch would hold its old value and infer a latch.
  always_comb begin
    rd_next = '0;
    if (rd_addr == PERIOD_ADDR) rd_next = period_sh;
    if (rd_addr == CTRL_ADDR)   rd_next = {{(W-1){1'b0}}, pending};
    for (int i = 0; i < CORE_WIDTH; i++) begin
      if (rd_addr == ADDR_WIDTH'(i + 1)) rd_next = duty_sh[i];
    end
  end

  always_comb begin
    duty = '0;
    for (int i = 0; i < CORE_WIDTH; i++) begin
      duty[i*W +: W] = duty_act[i];
    end
  end

  // NOTE: state is updated with <= only, so every right-hand side below sees the
  // pre-edge value; a commit therefore captures the shadows as they were before
  // any write landing on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the shadow and active arrays are reset explicitly because readback
      // and the PWM core both rely on them being 0 right after reset.
      period_sh   <= '0;
      period      <= '0;
      for (int i = 0; i < CORE_WIDTH; i++) begin
        duty_sh[i]  <= '0;
        duty_act[i] <= '0;
      end
      cnt         <= '0;
      pending     <= 1'b0;
      rd_data     <= '0;
      commit_done <= 1'b0;
    end else begin
      rd_data     <= rd_next;
      cnt         <= wrap ? '0 : cnt + W'(1);
      pending     <= pending_next;
      commit_done <= commit;
      if (commit) begin
        period <= period_sh;
        for (int i = 0; i < CORE_WIDTH; i++) duty_act[i] <= duty_sh[i];
      end
      if (wr_en && (wr_addr == PERIOD_ADDR)) period_sh <= wr_data;
      for (int i = 0; i < CORE_WIDTH; i++) begin
        if (wr_en && (wr_addr == ADDR_WIDTH'(i + 1))) duty_sh[i] <= wr_data;
      end
    end
  end

endmodule

// File: doc/pwm_config_sync.md
Name: pwm_config_sync

Overview:
- Upstream configuration stage for the GPIO PWM core.
- Holds bus-writable shadow copies of the period and per-channel duty values.
- Transfers them atomically to the active outputs that drive the PWM core, only at a PWM frame boundary, so outputs never glitch mid-frame.
- Tracks the frame boundary with an internal mirror counter that follows exactly the same counting rule as the PWM core's counter. Both blocks come out of reset together, so they stay in lock-step.

Parameters:
- CORE_WIDTH, 4, number of PWM channels.
- PWM_COUNTER_WIDTH, 16, width of the period, duty and counter values.
- ADDR_WIDTH, 4, register address width. Must satisfy 2^ADDR_WIDTH >= CORE_WIDTH+2.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- wr_en  in  1  register write strobe, single-cycle.
- wr_addr  in  ADDR_WIDTH  write address.
- wr_data  in  PWM_COUNTER_WIDTH  write data.
- rd_addr  in  ADDR_WIDTH  read address, sampled every cycle.
- rd_data  out  PWM_COUNTER_WIDTH  registered read data.
- period  out  PWM_COUNTER_WIDTH  active period, to the PWM core.
- duty  out  PWM_COUNTER_WIDTH*CORE_WIDTH+1  active duties. Channel i occupies bits [(i+1)*W-1 : i*W]; the MSB is always 0.
- pending  out  1  commit armed, not yet applied.
- frame_start  out  1  one-cycle pulse on the cycle the mirror counter equals 0.
- commit_done  out  1  one-cycle pulse on the cycle after active registers load.

Behaviour:
- Reset (rst=1 at a clk edge): all shadow and active registers clear to 0, mirror counter 0, pending 0, rd_data 0, commit_done 0. frame_start is combinational from the counter, so it reads 1 after reset.
- Address map:
  - 0 = period shadow.
  - 1..CORE_WIDTH = duty shadow for channel addr-1.
  - CORE_WIDTH+1 = control. Write: bit0 arm, bit1 abort. Read: {0…, pending}.
  - Other addresses: writes ignored, reads return 0.
- Shadow writes:
  - Take effect at the next edge. Readback shows the shadow value, never the active value.
  - A shadow write while pending=1 is accepted, and the latest value is what gets committed.
- Mirror counter:
  - wrap = (cnt > period_active) OR (cnt == all-ones).
  - On wrap, cnt <= 0; otherwise cnt <= cnt+1.
  - Frame length is therefore period_active+2 cycles, or 2^W cycles when period_active = all-ones.
  - period_active = 0 gives the sequence 0,1,0,1,…
- Commit:
  - Control write with bit0=1 and bit1=0 sets pending at the next edge.
  - At an edge where wrap=1 and pending=1: period/duty active <= shadows, pending <= 0, commit_done <= 1 for the next cycle.
  - The active outputs change on the same edge at which cnt becomes 0, matching the PWM core's counter reset.
  - The mirror counter uses the old period for the wrap decision at that edge.
- Simultaneous arm write and wrap in the same cycle: commit happens at that edge, pending stays 0, commit_done pulses.
- Abort: control write with bit1=1 clears pending at the next edge, with no commit. If bit0 and bit1 are both set, abort wins. Abort in the same cycle as wrap with pending=1 also wins: no load.
- Arm while already pending: no effect beyond keeping pending=1.
- rd_data latency: 1 cycle. It reflects register state before any write in the same cycle.
- Reset mid-frame or while pending: everything returns to reset values; any armed commit is lost.

Test Plan:
- Reset, then read addrs 0..5 → all 0. Wait 2 cycles after reset → frame_start toggles every cycle (period 0 gives a 2-cycle frame; pulses every 2nd cycle).
- Write period=9, duty0=3, arm; then mirror cnt wraps → period/duty0 change exactly on the edge cnt goes 0, commit_done pulses once, pending 1→0. Subsequent frames are 11 cycles.
- With period=9 active, write duty1=5 without arming → duty output unchanged for 3 frames; readback of addr 2 = 5.
- Arm, write duty0=7 before wrap, then wrap → committed duty0=7. Arm then abort before wrap → no change, pending=0, no commit_done.
- Arm write issued on the exact wrap cycle → load at that edge. Write control=0b11 → pending stays 0.
- Period=0xFFFF committed → frame 65536 cycles, wrap via overflow. Assert rst mid-frame with pending=1 → all outputs 0, pending 0.
